// File: rtl/exe_wb_scalar_queue_pkg.sv
// Shared types for the scalar execute-to-writeback result queue.
package exe_wb_scalar_queue_pkg;

  // One scalar result travelling from an execution unit to writeback.
  typedef struct packed {
    logic        valid;
    logic [63:0] pc;
    logic [4:0]  rd;
    logic [63:0] result;
  } exe_wb_scalar_instr_t;

  // Occupancy counter width: must be able to hold the value DEPTH itself.
  function automatic int unsigned cnt_width(input int unsigned depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/exe_wb_scalar_queue_if.sv
// Bus between the execution units / writeback stage and the result queue.
interface exe_wb_scalar_queue_if
  import exe_wb_scalar_queue_pkg::*;
#(
  parameter int unsigned DEPTH = 4
);
  localparam int unsigned CNT_W = cnt_width(DEPTH);

  exe_wb_scalar_instr_t instr_a_i;   // ALU result
  exe_wb_scalar_instr_t instr_b_i;   // long-latency unit result
  logic                 wb_ready_i;  // writeback takes instr_o this cycle
  exe_wb_scalar_instr_t instr_o;     // head entry
  logic                 stall_o;
  logic [CNT_W-1:0]     count_o;
  logic                 overflow_o;

  // Environment side: drives results and ready, observes the queue.
  modport master (
    output instr_a_i, instr_b_i, wb_ready_i,
    input  instr_o, stall_o, count_o, overflow_o
  );

  // Queue side.
  modport slave (
    input  instr_a_i, instr_b_i, wb_ready_i,
    output instr_o, stall_o, count_o, overflow_o
  );
endinterface

// File: rtl/exe_wb_queue_ptr.sv
// Head/tail/count bookkeeping for the result queue, including acceptance of
// up to two writes per cycle, stall generation and the sticky overflow flag.
module exe_wb_queue_ptr #(
  parameter int unsigned DEPTH = 4
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       i_flush,
  input  logic                       i_valid_a,
  input  logic                       i_valid_b,
  input  logic                       i_deq,
  output logic [$clog2(DEPTH)-1:0]   o_head,
  output logic [$clog2(DEPTH)-1:0]   o_wr_idx_a,
  output logic [$clog2(DEPTH)-1:0]   o_wr_idx_b,
  output logic                       o_wr_a,
  output logic                       o_wr_b,
  output logic [$clog2(DEPTH):0]     o_count,
  output logic                       o_stall,
  output logic                       o_overflow
);
  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [PTR_W-1:0] r_head, r_tail;
  logic [CNT_W-1:0] r_count;
  logic             r_stall, r_overflow;

  logic [CNT_W-1:0] w_free, w_count_next;
  logic             w_acc_a, w_acc_b, w_drop;
  logic [1:0]       w_n_acc;

  // Acceptance: A takes the first free slot, B the next; a same-cycle dequeue frees one.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    w_free       = CNT_W'(DEPTH) - r_count + CNT_W'(i_deq);
    w_acc_a      = i_valid_a && !i_flush && (w_free != '0);
    w_acc_b      = i_valid_b && !i_flush && (w_free > CNT_W'(w_acc_a));
    w_drop       = !i_flush && ((i_valid_a && !w_acc_a) || (i_valid_b && !w_acc_b));
    w_n_acc      = {1'b0, w_acc_a} + {1'b0, w_acc_b};
    w_count_next = r_count + CNT_W'(w_n_acc) - CNT_W'(i_deq);
  end

  // Pointer, occupancy, stall and overflow state; reset beats flush beats normal flow.
  always_ff @(posedge clk_i) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (rst_i) begin
      r_head     <= '0;
      r_tail     <= '0;
      r_count    <= '0;
      r_stall    <= 1'b0;
      r_overflow <= 1'b0;
    end else if (i_flush) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
      r_stall <= 1'b0;
    end else begin
      r_head  <= r_head + PTR_W'(i_deq);
      r_tail  <= r_tail + PTR_W'(w_n_acc);
      r_count <= w_count_next;
      r_stall <= (CNT_W'(DEPTH) - w_count_next) < CNT_W'(2);
      if (w_drop) r_overflow <= 1'b1;
    end
  end

  assign o_head     = r_head;
  assign o_wr_idx_a = r_tail;
  assign o_wr_idx_b = w_acc_a ? r_tail + PTR_W'(1) : r_tail;
  assign o_wr_a     = w_acc_a;
  assign o_wr_b     = w_acc_b;
  assign o_count    = r_count;
  assign o_stall    = r_stall;
  assign o_overflow = r_overflow;
endmodule

// File: rtl/exe_wb_scalar_queue.sv
// In-order result buffer between the scalar execution units and the single
// scalar writeback port. Two enqueue ports (A before B), one dequeue port.
module exe_wb_scalar_queue
  import exe_wb_scalar_queue_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  input  logic                        flush_i,
  exe_wb_scalar_queue_if.slave        bus
);
  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  exe_wb_scalar_instr_t r_mem [DEPTH];

  logic [PTR_W-1:0] w_head, w_wr_idx_a, w_wr_idx_b;
  logic             w_wr_a, w_wr_b, w_deq, w_stall, w_overflow;
  logic [CNT_W-1:0] w_count;

  assign w_deq = (w_count != '0) && bus.wb_ready_i;

  exe_wb_queue_ptr #(.DEPTH(DEPTH)) u_ptr (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .i_flush    (flush_i),
    .i_valid_a  (bus.instr_a_i.valid),
    .i_valid_b  (bus.instr_b_i.valid),
    .i_deq      (w_deq),
    .o_head     (w_head),
    .o_wr_idx_a (w_wr_idx_a),
    .o_wr_idx_b (w_wr_idx_b),
    .o_wr_a     (w_wr_a),
    .o_wr_b     (w_wr_b),
    .o_count    (w_count),
    .o_stall    (w_stall),
    .o_overflow (w_overflow)
  );

  // Storage writes for accepted results; the two slots never coincide.
  always_ff @(posedge clk_i) begin
    // NOTE: storage is not reset; the output mux hides stale slots whenever the queue is empty.
    if (w_wr_a) r_mem[w_wr_idx_a] <= bus.instr_a_i;
    if (w_wr_b) r_mem[w_wr_idx_b] <= bus.instr_b_i;
  end

  // Head slot drives writeback directly; all-zero when the queue is empty.
  always_comb begin
    bus.instr_o = '0;
    if (w_count != '0) begin
      bus.instr_o       = r_mem[w_head];
      bus.instr_o.valid = 1'b1;
    end
  end

  assign bus.count_o    = w_count;
  assign bus.stall_o    = w_stall;
  assign bus.overflow_o = w_overflow;
endmodule

// File: tb/tb_exe_wb_scalar_queue.sv
// Directed and randomized checks of exe_wb_scalar_queue against a queue-based
// behavioural model.
module tb_exe_wb_scalar_queue;
  import exe_wb_scalar_queue_pkg::*;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic flush = 1'b0;

  exe_wb_scalar_queue_if #(.DEPTH(DEPTH)) dif ();

  exe_wb_scalar_queue #(.DEPTH(DEPTH)) dut (
    .clk_i   (clk),
    .rst_i   (rst),
    .flush_i (flush),
    .bus     (dif.slave)
  );

  always #5 clk = ~clk;

  // Reference model state
  exe_wb_scalar_instr_t m_q[$];
  logic                 m_ovf   = 1'b0;
  logic                 m_stall = 1'b0;

  int n_assert = 0;
  int n_fail   = 0;

  exe_wb_scalar_instr_t none = '0;

  function automatic exe_wb_scalar_instr_t mk(input logic [63:0] res);
    exe_wb_scalar_instr_t r;
    r.valid  = 1'b1;
    r.pc     = {$urandom, $urandom};
    r.rd     = 5'($urandom);
    r.result = res;
    return r;
  endfunction

  // One clock edge of the queue, from the rules: deliver, then flush, then accept A then B.
  task automatic model_step(input exe_wb_scalar_instr_t a, input exe_wb_scalar_instr_t b,
                            input logic rdy, input logic fl, input logic rs);
    if (rs) begin
      m_q.delete();
      m_ovf   = 1'b0;
      m_stall = 1'b0;
      return;
    end
    if (m_q.size() > 0 && rdy) void'(m_q.pop_front());
    if (fl) begin
      m_q.delete();
      m_stall = 1'b0;
      return;
    end
    if (a.valid) begin
      if (m_q.size() < int'(DEPTH)) m_q.push_back(a);
      else m_ovf = 1'b1;
    end
    if (b.valid) begin
      if (m_q.size() < int'(DEPTH)) m_q.push_back(b);
      else m_ovf = 1'b1;
    end
    m_stall = (int'(DEPTH) - m_q.size()) < 2;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs(input string tag);
    exe_wb_scalar_instr_t exp;
    exp = '0;
    if (m_q.size() > 0) exp = m_q[0];
    n_assert++;
    assert (dif.instr_o === exp) else begin
      n_fail++;
      $error("FAIL %s.instr_o observed=%h expected=%h", tag, dif.instr_o, exp);
    end
    n_assert++;
    assert (dif.count_o === CNT_W'(m_q.size())) else begin
      n_fail++;
      $error("FAIL %s.count_o observed=%0d expected=%0d", tag, dif.count_o, m_q.size());
    end
    n_assert++;
    assert (dif.stall_o === m_stall) else begin
      n_fail++;
      $error("FAIL %s.stall_o observed=%b expected=%b", tag, dif.stall_o, m_stall);
    end
    n_assert++;
    assert (dif.overflow_o === m_ovf) else begin
      n_fail++;
      $error("FAIL %s.overflow_o observed=%b expected=%b", tag, dif.overflow_o, m_ovf);
    end
  endtask

  // Drive one cycle of inputs, advance one edge, update the model, check #1 later.
  task automatic cycle(input exe_wb_scalar_instr_t a, input exe_wb_scalar_instr_t b,
                       input logic rdy, input logic fl, input logic rs, input string tag);
    dif.instr_a_i  = a;
    dif.instr_b_i  = b;
    dif.wb_ready_i = rdy;
    flush          = fl;
    rst            = rs;
    @(posedge clk);
    model_step(a, b, rdy, fl, rs);
    #1;
    check_outputs(tag);
  endtask

  initial begin
    exe_wb_scalar_instr_t ra, rb;
    logic rrdy, rfl, rrs;

    dif.instr_a_i  = '0;
    dif.instr_b_i  = '0;
    dif.wb_ready_i = 1'b0;

    // Reset
    cycle(none, none, 1'b0, 1'b0, 1'b1, "reset0");
    cycle(none, none, 1'b0, 1'b0, 1'b1, "reset1");
    check("reset_valid", 64'(dif.instr_o.valid), 64'h0);
    check("reset_count", 64'(dif.count_o), 64'h0);

    // Single entry through with ready high
    cycle(mk(64'h5), none, 1'b1, 1'b0, 1'b0, "t1_push");
    check("t1_valid", 64'(dif.instr_o.valid), 64'h1);
    check("t1_result", dif.instr_o.result, 64'h5);
    cycle(none, none, 1'b1, 1'b0, 1'b0, "t1_drain");
    check("t1_empty_count", 64'(dif.count_o), 64'h0);

    // Dual enqueue, A ordered before B
    cycle(mk(64'h11), mk(64'h22), 1'b0, 1'b0, 1'b0, "t2_push");
    check("t2_count", 64'(dif.count_o), 64'h2);
    check("t2_head", dif.instr_o.result, 64'h11);
    cycle(none, none, 1'b1, 1'b0, 1'b0, "t2_deq1");
    check("t2_second", dif.instr_o.result, 64'h22);
    cycle(none, none, 1'b1, 1'b0, 1'b0, "t2_deq2");

    // Fill to DEPTH, same-cycle free slot, then overflow
    cycle(mk(64'h31), mk(64'h32), 1'b0, 1'b0, 1'b0, "t3_fill1");
    cycle(mk(64'h33), mk(64'h34), 1'b0, 1'b0, 1'b0, "t3_fill2");
    check("t3_full_count", 64'(dif.count_o), 64'h4);
    check("t3_full_stall", 64'(dif.stall_o), 64'h1);
    check("t3_no_ovf", 64'(dif.overflow_o), 64'h0);
    cycle(mk(64'h35), none, 1'b1, 1'b0, 1'b0, "t4_full_deq_push");
    check("t4_count", 64'(dif.count_o), 64'h4);
    check("t4_no_ovf", 64'(dif.overflow_o), 64'h0);
    check("t4_head", dif.instr_o.result, 64'h32);
    cycle(mk(64'h36), none, 1'b0, 1'b0, 1'b0, "t3_overflow");
    check("t3_ovf", 64'(dif.overflow_o), 64'h1);
    check("t3_ovf_count", 64'(dif.count_o), 64'h4);
    cycle(none, none, 1'b0, 1'b1, 1'b0, "t3_flush");
    check("t3_ovf_kept", 64'(dif.overflow_o), 64'h1);

    // Streaming across pointer wrap
    for (int i = 1; i <= 10; i++) begin
      cycle(mk(64'(i)), none, 1'b1, 1'b0, 1'b0, "t5_stream");
      check("t5_order", dif.instr_o.result, 64'(i));
    end
    cycle(none, none, 1'b1, 1'b0, 1'b0, "t5_drain");

    // Flush with buffered entries and a same-cycle push
    for (int i = 0; i < 3; i++) cycle(mk(64'h40 + 64'(i)), none, 1'b0, 1'b0, 1'b0, "t6_fill");
    check("t6_stall_before", 64'(dif.stall_o), 64'h1);
    cycle(mk(64'h99), none, 1'b0, 1'b1, 1'b0, "t6_flush");
    check("t6_count", 64'(dif.count_o), 64'h0);
    check("t6_valid", 64'(dif.instr_o.valid), 64'h0);
    check("t6_stall", 64'(dif.stall_o), 64'h0);
    cycle(none, none, 1'b1, 1'b0, 1'b0, "t6_after");
    check("t6_never_seen", 64'(dif.instr_o.valid), 64'h0);

    // Randomized traffic against the model
    cycle(none, none, 1'b0, 1'b0, 1'b1, "rand_reset");
    for (int n = 0; n < 500; n++) begin
      ra   = ($urandom % 3 != 0) ? mk({$urandom, $urandom}) : '0;
      rb   = ($urandom % 2 != 0) ? mk({$urandom, $urandom}) : '0;
      rrdy = ($urandom % 4 != 0);
      rfl  = ($urandom % 25 == 0);
      rrs  = ($urandom % 150 == 0);
      cycle(ra, rb, rrdy, rfl, rrs, "rand");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
